// File: rtl/apu_i2s_tx.sv
// I2S transmitter at the end of the APU audio path: a small sample FIFO feeding
// a bclk/lrclk/sdata serialiser that sends each mono word in both slots.
module apu_i2s_tx #(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [15:0]                 sample_i,
  input  logic                        sample_valid_i,
  output logic                        sample_ready_o,
  input  logic                        mute_i,
  input  logic                        clr_underrun_i,
  output logic                        bclk_o,
  output logic                        lrclk_o,
  output logic                        sdata_o,
  output logic                        underrun_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_ZERO   = {DW{1'b0}};
  localparam logic [DW-1:0] DIV_ONE    = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   LEVEL_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   LEVEL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

  logic [15:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [DW-1:0] div_cnt_r;
  logic [4:0]    bit_cnt_r;
  logic [15:0]   out_word_r;
  logic          bclk_r;
  logic          lrclk_r;
  logic          sdata_r;
  logic          underrun_r;

  logic          div_wrap_s;
  logic          fall_s;
  logic          load_s;
  logic          push_s;
  logic          pop_s;
  logic [4:0]    n_s;
  logic [15:0]   out_word_nxt_s;
  logic          underrun_nxt_s;
  logic [AW:0]   level_nxt_s;

  assign sample_ready_o = ~rst_i & (level_r != LEVEL_FULL);

  // Event decode: bclk fall, frame load, FIFO push/pop and next-state values
  always_comb begin
    div_wrap_s     = (div_cnt_r == DIV_LAST);
    fall_s         = div_wrap_s & bclk_r;
    n_s            = bit_cnt_r + 5'd1;
    load_s         = fall_s & (n_s == 5'd31);
    push_s         = sample_valid_i & sample_ready_o;
    pop_s          = load_s & (level_r != LEVEL_ZERO);
    out_word_nxt_s = out_word_r;
    underrun_nxt_s = underrun_r;
    level_nxt_s    = level_r;
    if (load_s) begin
      if (mute_i) begin
        out_word_nxt_s = 16'h0000;
      end else if (pop_s) begin
        out_word_nxt_s = fifo_mem_r[rd_ptr_r];
      end else begin
        out_word_nxt_s = out_word_r;
      end
    end else begin
      out_word_nxt_s = out_word_r;
    end
    // An empty-FIFO load wins over a same-cycle clear
    if (load_s && !pop_s) begin
      underrun_nxt_s = 1'b1;
    end else if (clr_underrun_i) begin
      underrun_nxt_s = 1'b0;
    end else begin
      underrun_nxt_s = underrun_r;
    end
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LEVEL_ONE;
      2'b01:   level_nxt_s = level_r - LEVEL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Sample FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 16'h0000;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_ZERO;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= sample_i;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
    end
  end

  // Bit-clock divider
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_r <= DIV_ZERO;
      bclk_r    <= 1'b0;
    end else if (div_wrap_s) begin
      div_cnt_r <= DIV_ZERO;
      bclk_r    <= ~bclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Serialiser: both slots read out_word MSB-first, so bit index is ~n[3:0]
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_r  <= 5'd30;
      lrclk_r    <= 1'b1;
      sdata_r    <= 1'b0;
      out_word_r <= 16'h0000;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_nxt_s;
      if (fall_s) begin
        bit_cnt_r  <= n_s;
        lrclk_r    <= (n_s >= 5'd15) && (n_s <= 5'd30);
        sdata_r    <= out_word_r[~n_s[3:0]];
        out_word_r <= out_word_nxt_s;
      end
    end
  end

  assign bclk_o       = bclk_r;
  assign lrclk_o      = lrclk_r;
  assign sdata_o      = sdata_r;
  assign underrun_o   = underrun_r;
  assign fifo_level_o = level_r;
endmodule

// File: tb/tb_apu_i2s_tx.sv
// Bench for apu_i2s_tx: cycle-level behavioural model checked every cycle, an
// I2S frame decoder, and directed scenarios with hand-computed expectations.
module tb_apu_i2s_tx;
  localparam int CLK_DIV     = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int FRAME_TICKS = 64 * CLK_DIV;

  logic        clk_i          = 1'b0;
  logic        rst_i          = 1'b1;
  logic [15:0] sample_i       = 16'h0000;
  logic        sample_valid_i = 1'b0;
  logic        mute_i         = 1'b0;
  logic        clr_underrun_i = 1'b0;
  logic        sample_ready_o;
  logic        bclk_o;
  logic        lrclk_o;
  logic        sdata_o;
  logic        underrun_o;
  logic [2:0]  fifo_level_o;

  always #5 clk_i = ~clk_i;

  apu_i2s_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .mute_i(mute_i), .clr_underrun_i(clr_underrun_i), .bclk_o(bclk_o),
    .lrclk_o(lrclk_o), .sdata_o(sdata_o), .underrun_o(underrun_o),
    .fifo_level_o(fifo_level_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time since reset drives the bit clock and frame position
  logic [15:0] m_q[$];
  logic [15:0] m_word;
  int          m_t;
  int          m_n;
  logic        m_bclk, m_lr, m_sd, m_und, m_room, m_set_und;

  function automatic bit next_is_load();
    return ((m_t + 1) % (2 * CLK_DIV) == 0) && ((((m_t + 1) / (2 * CLK_DIV)) % 32) == 1);
  endfunction

  always @(negedge clk_i) begin
    if (rst_i) begin
      m_q.delete();
      m_word = 16'h0000; m_t = 0; m_bclk = 1'b0; m_lr = 1'b1; m_sd = 1'b0; m_und = 1'b0;
    end else begin
      m_room    = (m_q.size() < FIFO_DEPTH);
      m_set_und = 1'b0;
      m_t++;
      m_bclk = ((m_t / CLK_DIV) % 2) == 1;
      if (m_t % (2 * CLK_DIV) == 0) begin
        m_n  = (30 + m_t / (2 * CLK_DIV)) % 32;
        m_lr = (m_n >= 15) && (m_n <= 30);
        m_sd = m_word[15 - (m_n % 16)];
        if (m_n == 31) begin
          if (m_q.size() > 0) m_word = m_q.pop_front();
          else m_set_und = 1'b1;
          if (mute_i) m_word = 16'h0000;
        end
      end
      if (m_set_und) m_und = 1'b1;
      else if (clr_underrun_i) m_und = 1'b0;
      if (sample_valid_i && m_room) m_q.push_back(sample_i);
    end
    check("bclk", bclk_o, m_bclk);
    check("lrclk", lrclk_o, m_lr);
    check("sdata", sdata_o, m_sd);
    check("underrun", underrun_o, m_und);
    check("level", fifo_level_o, m_q.size());
    check("ready", sample_ready_o, (!rst_i && m_q.size() < FIFO_DEPTH));
  end

  // Frame decoder: DAC-side sampling on bclk rises, one 32-bit word per frame
  logic [31:0] rx_q[$];
  logic [31:0] rx_lr_q[$];
  logic [31:0] mon_sd, mon_lr;
  int          mon_cnt;
  logic        mon_prev_b, mon_prev_lr;

  always @(negedge clk_i) begin
    if (rst_i) begin
      mon_cnt = 99; mon_prev_b = 1'b0; mon_prev_lr = 1'b1;
    end else begin
      if (bclk_o && !mon_prev_b) begin
        mon_sd = {mon_sd[30:0], sdata_o};
        mon_lr = {mon_lr[30:0], lrclk_o};
        mon_cnt++;
        if (!lrclk_o && mon_prev_lr) begin
          if (mon_cnt == 32) begin
            rx_q.push_back(mon_sd);
            rx_lr_q.push_back(mon_lr);
          end
          mon_cnt = 0;
        end
        mon_prev_lr = lrclk_o;
      end
      mon_prev_b = bclk_o;
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  task automatic flush();
    rx_q.delete();
    rx_lr_q.delete();
  endtask

  task automatic wait_frame(input string name, output logic [31:0] w, output logic [31:0] lr);
    int c;
    c = 0;
    while (rx_q.size() == 0 && c < 3 * FRAME_TICKS) begin
      tick();
      c++;
    end
    if (rx_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no frame within %0d cycles", name, 3 * FRAME_TICKS);
      w  = 32'h0;
      lr = 32'h0;
    end else begin
      w  = rx_q.pop_front();
      lr = rx_lr_q.pop_front();
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    sample_i       = d;
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_underrun_i = 1'b1;
    tick();
    clr_underrun_i = 1'b0;
  endtask

  initial begin
    logic [31:0] w, lr;
    logic [15:0] d[5];
    logic [15:0] fw[5];
    logic [15:0] exp3[3];
    logic [15:0] w6;
    logic        rdy, prev;
    int          cnt, npush, r1, r2;

    repeat (3) tick();
    check("rst_bclk", bclk_o, 32'd0);
    check("rst_lrclk", lrclk_o, 32'd1);
    check("rst_sdata", sdata_o, 32'd0);
    check("rst_ready", sample_ready_o, 32'd0);
    check("rst_level", fifo_level_o, 32'd0);

    // Single word, frame timing and bit order
    rst_i = 1'b0; sample_i = 16'hA5C3; sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    cnt = 1;
    while (lrclk_o && cnt < 20) begin tick(); cnt++; end
    check("first_fall_cycle", cnt, 32'd4);
    r1 = -1; r2 = -1; prev = bclk_o;
    for (int k = 0; k < 40 && r2 < 0; k++) begin
      tick();
      if (bclk_o && !prev) begin
        if (r1 < 0) r1 = k;
        else r2 = k;
      end
      prev = bclk_o;
    end
    check("bclk_period", r2 - r1, 32'd4);
    wait_frame("t1_frame", w, lr);
    check("t1_word", w, 32'hA5C3A5C3);
    check("t1_lrclk_pattern", lr, 32'h0001FFFE);

    // Back-to-back pushes against a 4-deep FIFO
    for (int k = 0; k < 5; k++) d[k] = 16'($urandom());
    npush = 0; sample_i = d[0]; sample_valid_i = 1'b1;
    for (int c = 0; c < 200 && npush < 5; c++) begin
      rdy = sample_ready_o;
      tick();
      if (rdy) begin
        npush++;
        if (npush == 4) begin
          check("t2_ready_full", sample_ready_o, 32'd0);
          check("t2_level_full", fifo_level_o, 32'd4);
        end
        if (npush < 5) sample_i = d[npush];
      end
    end
    sample_valid_i = 1'b0;
    check("t2_pushes", npush, 32'd5);
    wait_frame("t2_repeat_frame", w, lr);
    check("t2_repeat_word", w, 32'hA5C3A5C3);
    check("t2_underrun", underrun_o, 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_frame("t2_frame", w, lr);
      check("t2_word", w, {d[k], d[k]});
    end

    // Underrun repeat, clear, and a continuously fed stretch
    pulse_clr();
    check("t3_clr0", underrun_o, 32'd0);
    push_word(16'h1234);
    wait_frame("t3_pre", w, lr);
    check("t3_pre_word", w, {d[4], d[4]});
    wait_frame("t3_sent", w, lr);
    check("t3_sent_word", w, 32'h12341234);
    wait_frame("t3_repeat", w, lr);
    check("t3_repeat_word", w, 32'h12341234);
    check("t3_underrun_set", underrun_o, 32'd1);
    pulse_clr();
    check("t3_underrun_clr", underrun_o, 32'd0);
    for (int k = 0; k < 5; k++) fw[k] = 16'($urandom());
    exp3[0] = 16'h1234; exp3[1] = fw[0]; exp3[2] = fw[1];
    push_word(fw[0]);
    push_word(fw[1]);
    for (int k = 0; k < 3; k++) begin
      wait_frame("t3_fed", w, lr);
      check("t3_fed_word", w, {exp3[k], exp3[k]});
      check("t3_fed_underrun", underrun_o, 32'd0);
      push_word(fw[k + 2]);
    end

    // Mute on one load
    cnt = 0;
    while (fifo_level_o != 3'd0 && cnt < 4 * FRAME_TICKS) begin tick(); cnt++; end
    check("t4_drained", fifo_level_o, 32'd0);
    flush();
    wait_frame("t4_sync", w, lr);
    mute_i = 1'b1;
    push_word(16'h7FFF);
    push_word(16'h5A5A);
    wait_frame("t4_mute_load", w, lr);
    check("t4_level_after_mute", fifo_level_o, 32'd1);
    mute_i = 1'b0;
    wait_frame("t4_muted", w, lr);
    check("t4_muted_word", w, 32'h00000000);
    wait_frame("t4_next", w, lr);
    check("t4_next_word", w, 32'h5A5A5A5A);

    // Reset in the right slot with words queued
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    check("t5_level_q", fifo_level_o, 32'd3);
    cnt = 0;
    while (!lrclk_o && cnt < 2 * FRAME_TICKS) begin tick(); cnt++; end
    repeat (4) tick();
    rst_i = 1'b1;
    #1;
    check("t5_bclk", bclk_o, 32'd0);
    check("t5_lrclk", lrclk_o, 32'd1);
    check("t5_sdata", sdata_o, 32'd0);
    check("t5_underrun", underrun_o, 32'd0);
    check("t5_level", fifo_level_o, 32'd0);
    check("t5_ready", sample_ready_o, 32'd0);
    repeat (2) tick();
    rst_i = 1'b0;
    flush();
    wait_frame("t5_first", w, lr);
    check("t5_first_word", w, 32'h00000000);
    check("t5_first_underrun", underrun_o, 32'd1);

    // Push landing on an empty-FIFO load
    pulse_clr();
    cnt = 0;
    while (!next_is_load() && cnt < 3 * FRAME_TICKS) begin tick(); cnt++; end
    w6 = 16'($urandom());
    push_word(w6);
    check("t6_underrun", underrun_o, 32'd1);
    check("t6_level", fifo_level_o, 32'd1);
    repeat (4) tick();
    flush();
    wait_frame("t6_repeat", w, lr);
    check("t6_repeat_word", w, 32'h00000000);
    wait_frame("t6_word", w, lr);
    check("t6_word_sent", w, {w6, w6});

    // Random traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      sample_valid_i = ($urandom_range(0, 40) == 0);
      sample_i       = 16'($urandom());
      mute_i         = ($urandom_range(0, 15) == 0);
      clr_underrun_i = ($urandom_range(0, 60) == 0);
      rst_i          = (c >= 1500) && (c < 1502);
      tick();
    end
    sample_valid_i = 1'b0; mute_i = 1'b0; clr_underrun_i = 1'b0; rst_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
